exec_mc: RTL and testbench

EXEC_MC -- requirements
Module: exec_mc

---
 rtl/swt16_pkg.sv | 26 ++
 rtl/exec_mc_mul_iter.sv | 48 ++++
 rtl/exec_mc.sv | 128 ++++++++++++
 tb/tb_exec_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/swt16_pkg.sv
// Shared op encodings, execute-stage state encoding and default widths for the swt16 core.
package swt16_pkg;

   localparam int unsigned SWT16_WORD_WIDTH    = 16;
   localparam int unsigned SWT16_PC_WIDTH      = 12;
   localparam int unsigned SWT16_REG_IDX_WIDTH = 4;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_ADD   = 3'd1,
      OP_SUB   = 3'd2,
      OP_PASS2 = 3'd3,
      OP_MUL   = 3'd4,
      OP_BEQ   = 3'd5,
      OP_BLT   = 3'd6,
      OP_JMP   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/exec_mc_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product kept.
module mul_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else if (abort) begin
         count_q <= '0;
      end else if (start) begin
         a_q     <= op_a;
         b_q     <= op_b;
         acc_q   <= '0;
         count_q <= CW'(WIDTH);
      end else if (count_q != '0) begin
         if (b_q[0])
            acc_q <= acc_q + a_q;
         a_q     <= a_q << 1;
         b_q     <= b_q >> 1;
         count_q <= count_q - CW'(1);
      end
   end

   // High on the cycle whose edge performs the last iteration.
   assign done    = (count_q == CW'(1));
   assign product = acc_q;

endmodule

// File: rtl/exec_mc.sv
// Multi-cycle execute stage (ALU, branches, optional iterative MUL).
// Define EXEC_MC_MUL_EN to build the multiplier; otherwise MUL completes in EXEC with a zero result.
module exec_mc
   import swt16_pkg::*;
#(
   parameter int unsigned WORD_WIDTH    = SWT16_WORD_WIDTH,
   parameter int unsigned PC_WIDTH      = SWT16_PC_WIDTH,
   parameter int unsigned REG_IDX_WIDTH = SWT16_REG_IDX_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [2:0]               in_op,
   input  logic                     in_flush,
   input  logic [WORD_WIDTH-1:0]    in_src1,
   input  logic [WORD_WIDTH-1:0]    in_src2,
   input  logic [WORD_WIDTH-1:0]    in_src3,
   input  logic [REG_IDX_WIDTH-1:0] in_res_reg_idx,
   output logic                     out_ready,
   output logic                     out_valid,
   output logic [WORD_WIDTH-1:0]    out_res,
   output logic [REG_IDX_WIDTH-1:0] out_res_reg_idx,
   output logic                     out_wr_reg,
   output logic                     out_set_pc,
   output logic [PC_WIDTH-1:0]      out_branch_pc
);

   state_e                   state_q, state_d;
   op_e                      op_q;
   logic [WORD_WIDTH-1:0]    src1_q, src2_q;
   logic [PC_WIDTH-1:0]      target_q;
   logic [REG_IDX_WIDTH-1:0] idx_q;
   logic                     take;
   logic [WORD_WIDTH-1:0]    sum, diff;

   // A taken branch/jump squashes whatever would be captured on the same edge.
   assign take = in_valid && out_ready && !in_flush && !out_set_pc;
   assign sum  = src1_q + src2_q;
   assign diff = src1_q - src2_q;

`ifdef EXEC_MC_MUL_EN
   logic                  mul_done;
   logic [WORD_WIDTH-1:0] mul_product;

   assign out_ready = (state_q != ST_MUL);

   mul_iter #(.WIDTH(WORD_WIDTH)) u_mul (
      .clock   (clock),
      .reset   (reset),
      .start   (take && (in_op == OP_MUL)),
      .abort   (in_flush),
      .op_a    (in_src1),
      .op_b    (in_src2),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign out_ready = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_NOP;
         src1_q   <= '0;
         src2_q   <= '0;
         target_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            op_q     <= op_e'(in_op);
            src1_q   <= in_src1;
            src2_q   <= in_src2;
            target_q <= in_src3[PC_WIDTH-1:0];
            idx_q    <= in_res_reg_idx;
         end
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      if (in_flush || out_set_pc)
         state_d = ST_IDLE;
`ifdef EXEC_MC_MUL_EN
      else if (take)
         state_d = (in_op == OP_MUL) ? ST_MUL : ST_EXEC;
      else if (state_q == ST_MUL)
         state_d = mul_done ? ST_DONE : ST_MUL;
`else
      else if (take)
         state_d = ST_EXEC;
`endif
   end

   always_comb begin
      out_valid       = 1'b0;
      out_res         = '0;
      out_res_reg_idx = '0;
      out_wr_reg      = 1'b0;
      out_set_pc      = 1'b0;
      out_branch_pc   = '0;
      if (state_q == ST_EXEC) begin
         out_valid       = 1'b1;
         out_res_reg_idx = idx_q;
         case (op_q)
            OP_ADD:   begin out_res = sum;    out_wr_reg = 1'b1; end
            OP_SUB:   begin out_res = diff;   out_wr_reg = 1'b1; end
            OP_PASS2: begin out_res = src2_q; out_wr_reg = 1'b1; end
            OP_BEQ:   out_set_pc = (diff == '0);
            OP_BLT:   out_set_pc = diff[WORD_WIDTH-1];
            OP_JMP:   out_set_pc = 1'b1;
            default:  ;
         endcase
         if (out_set_pc)
            out_branch_pc = (op_q == OP_JMP) ? sum[PC_WIDTH-1:0] : target_q;
      end
`ifdef EXEC_MC_MUL_EN
      else if (state_q == ST_DONE) begin
         out_valid       = 1'b1;
         out_res         = mul_product;
         out_res_reg_idx = idx_q;
         out_wr_reg      = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_exec_mc.sv
// Directed self-checking bench for exec_mc; MUL expectations follow EXEC_MC_MUL_EN.
module tb_exec_mc;
   import swt16_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [2:0]  in_op;
   logic        in_flush;
   logic [15:0] in_src1, in_src2, in_src3;
   logic [3:0]  in_res_reg_idx;
   logic        out_ready, out_valid, out_wr_reg, out_set_pc;
   logic [15:0] out_res;
   logic [3:0]  out_res_reg_idx;
   logic [11:0] out_branch_pc;

   int checks   = 0;
   int failures = 0;

   exec_mc #(.WORD_WIDTH(16), .PC_WIDTH(12), .REG_IDX_WIDTH(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_op           (in_op),
      .in_flush        (in_flush),
      .in_src1         (in_src1),
      .in_src2         (in_src2),
      .in_src3         (in_src3),
      .in_res_reg_idx  (in_res_reg_idx),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .out_res         (out_res),
      .out_res_reg_idx (out_res_reg_idx),
      .out_wr_reg      (out_wr_reg),
      .out_set_pc      (out_set_pc),
      .out_branch_pc   (out_branch_pc)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic rdy, input logic vld,
                             input logic [15:0] res, input logic wr, input logic [3:0] idx,
                             input logic spc, input logic [11:0] pc);
      check({tag, ".ready"}, 32'(out_ready), 32'(rdy));
      check({tag, ".valid"}, 32'(out_valid), 32'(vld));
      check({tag, ".res"},   32'(out_res), 32'(res));
      check({tag, ".wr"},    32'(out_wr_reg), 32'(wr));
      check({tag, ".idx"},   32'(out_res_reg_idx), 32'(idx));
      check({tag, ".setpc"}, 32'(out_set_pc), 32'(spc));
      check({tag, ".pc"},    32'(out_branch_pc), 32'(pc));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                        input logic [15:0] s3, input logic [3:0] idx);
      in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_src3 = s3;
      in_res_reg_idx = idx;
      step();
      in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0; in_src3 = '0;
      in_res_reg_idx = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, low;
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_flush = 1'b0;
      in_src1 = '0; in_src2 = '0; in_src3 = '0; in_res_reg_idx = '0;
      #1;
      check_outs("reset_during", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      step();
      check_outs("idle_after_reset", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);

      issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 4'd3);
      check_outs("add_wrap", 1, 1, 16'h8000, 1, 4'd3, 0, 12'h0);
      step();
      check_outs("idle_after_add", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);

      issue(OP_SUB, 16'h0005, 16'h0007, 16'h0, 4'd2);
      check_outs("sub_neg", 1, 1, 16'hFFFE, 1, 4'd2, 0, 12'h0);
      issue(OP_PASS2, 16'h1111, 16'hABCD, 16'h0, 4'd9);
      check_outs("pass2_b2b", 1, 1, 16'hABCD, 1, 4'd9, 0, 12'h0);
      issue(OP_NOP, 16'h1234, 16'h5678, 16'h0, 4'd1);
      check_outs("nop", 1, 1, 16'h0, 0, 4'd1, 0, 12'h0);

      issue(OP_BEQ, 16'h0009, 16'h0009, 16'h1456, 4'd0);
      check_outs("beq_taken", 1, 1, 16'h0, 0, 4'd0, 1, 12'h456);
      step();
      check("beq_after.valid", 32'(out_valid), 32'd0);

      issue(OP_BEQ, 16'h0009, 16'h0008, 16'h1456, 4'd0);
      check_outs("beq_not", 1, 1, 16'h0, 0, 4'd0, 0, 12'h0);

      issue(OP_BLT, 16'h0002, 16'h0005, 16'h0123, 4'd0);
      check_outs("blt_taken", 1, 1, 16'h0, 0, 4'd0, 1, 12'h123);
      in_valid = 1'b1; in_op = OP_ADD; in_src1 = 16'd1; in_src2 = 16'd1; in_res_reg_idx = 4'd5;
      step();
      in_valid = 1'b0; in_op = '0;
      check_outs("blt_squash1", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);
      step();
      check("blt_squash2.valid", 32'(out_valid), 32'd0);

      issue(OP_BLT, 16'h8000, 16'h0001, 16'h0777, 4'd0);
      check_outs("blt_ovf_not", 1, 1, 16'h0, 0, 4'd0, 0, 12'h0);

      issue(OP_JMP, 16'h0FF0, 16'h1020, 16'hFFFF, 4'd0);
      check_outs("jmp", 1, 1, 16'h0, 0, 4'd0, 1, 12'h010);

      in_flush = 1'b1;
      issue(OP_ADD, 16'h0003, 16'h0004, 16'h0, 4'd6);
      in_flush = 1'b0;
      check_outs("flush_wins", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);

`ifdef EXEC_MC_MUL_EN
      issue(OP_MUL, 16'h0012, 16'h0034, 16'h0, 4'd7);
      cyc = 0; low = 0;
      while (!out_valid && cyc < 40) begin
         if (!out_ready) low++;
         step();
         cyc++;
      end
      check("mul_ready_low_cycles", 32'(low), 32'd16);
      check_outs("mul_result", 1, 1, 16'h03A8, 1, 4'd7, 0, 12'h0);
      issue(OP_ADD, 16'h0001, 16'h0001, 16'h0, 4'd4);
      check_outs("capture_in_done", 1, 1, 16'h0002, 1, 4'd4, 0, 12'h0);

      issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0, 4'd8);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         step();
         cyc++;
      end
      check("mul_ffff_latency", 32'(cyc), 32'd16);
      check_outs("mul_ffff", 1, 1, 16'h0001, 1, 4'd8, 0, 12'h0);
      step();

      issue(OP_MUL, 16'h0003, 16'h0005, 16'h0, 4'd2);
      repeat (4) step();
      check("mul_busy_before_flush.ready", 32'(out_ready), 32'd0);
      in_flush = 1'b1;
      step();
      in_flush = 1'b0;
      check_outs("mul_flushed", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);
      cyc = 0;
      repeat (20) begin
         step();
         if (out_valid) cyc++;
      end
      check("mul_flushed_no_result", 32'(cyc), 32'd0);

      issue(OP_MUL, 16'h0007, 16'h0009, 16'h0, 4'd2);
      repeat (3) step();
      reset = 1'b1;
      #1;
      check_outs("reset_mid_mul", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);
      @(negedge clock);
      reset = 1'b0;
      issue(OP_ADD, 16'h0001, 16'h0001, 16'h0, 4'd1);
      check_outs("add_after_reset", 1, 1, 16'h0002, 1, 4'd1, 0, 12'h0);
      cyc = 0;
      repeat (20) begin
         step();
         if (out_valid) cyc++;
      end
      check("reset_mul_no_result", 32'(cyc), 32'd0);
`else
      issue(OP_MUL, 16'h0003, 16'h0004, 16'h0, 4'd7);
      check_outs("mul_disabled", 1, 1, 16'h0, 0, 4'd7, 0, 12'h0);
      step();
      check_outs("mul_disabled_after", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);

      issue(OP_ADD, 16'h0010, 16'h0020, 16'h0, 4'd2);
      reset = 1'b1;
      #1;
      check_outs("reset_async", 1, 0, 16'h0, 0, 4'h0, 0, 12'h0);
      @(negedge clock);
      reset = 1'b0;
      issue(OP_ADD, 16'h0001, 16'h0001, 16'h0, 4'd1);
      check_outs("add_after_reset", 1, 1, 16'h0002, 1, 4'd1, 0, 12'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
